// File: rtl/btle_hci_cmd_parser_pkg.sv
// Shared HCI definitions: packet indicator, error codes and parser state encoding.
// The future event-packet encoder reuses these definitions.
package btle_hci_cmd_parser_pkg;

  localparam logic [7:0] HCI_PKT_CMD = 8'h01;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_IND  = 3'd1;
  localparam logic [2:0] ERR_FRAMING  = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPC_LO   = 3'd1,
    ST_OPC_HI   = 3'd2,
    ST_PLEN     = 3'd3,
    ST_PARAM    = 3'd4,
    ST_DISCARD  = 3'd5,
    ST_WAIT_ACK = 3'd6
  } state_t;

endpackage

// File: rtl/btle_hci_cmd_parser.sv
// UART-HCI command packet parser: streams params into the link layer's buffer and
// presents opcode/length with a valid/ready handshake; errors reported as 1-cycle pulses.
module btle_hci_cmd_parser
  import btle_hci_cmd_parser_pkg::*;
#(
  parameter int CLK_FREQUENCE = 16_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int MAX_PARAM_LEN = 64,
  parameter int TIMEOUT_BYTES = 4,
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQUENCE / BAUD_RATE),
  localparam int PADDR_W = $clog2(MAX_PARAM_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_frame,
  input  logic               rx_done,
  input  logic               frame_error,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [15:0]        cmd_opcode,
  output logic [7:0]         cmd_param_len,
  output logic               param_we,
  output logic [PADDR_W-1:0] param_addr,
  output logic [7:0]         param_data,
  output logic               err_pulse,
  output logic [2:0]         err_code
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_nxt;
  logic [TO_W-1:0] tmr, tmr_nxt;
  // 8-bit byte counter: also walks oversize packets (up to 255 bytes) in DISCARD
  logic [7:0] cnt, cnt_nxt;

  logic               valid_nxt;
  logic [15:0]        opcode_nxt;
  logic [7:0]         len_nxt;
  logic               we_nxt;
  logic [PADDR_W-1:0] addr_nxt;
  logic [7:0]         data_nxt;
  logic               err_nxt;
  logic [2:0]         code_nxt;
  logic               accept;
  logic               last_byte;

  assign accept    = rx_done & ~frame_error;
  assign last_byte = (cnt == cmd_param_len - 8'd1);

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr + TO_W'(1);
    cnt_nxt    = cnt;
    valid_nxt  = cmd_valid;
    opcode_nxt = cmd_opcode;
    len_nxt    = cmd_param_len;
    we_nxt     = 1'b0;
    addr_nxt   = param_addr;
    data_nxt   = param_data;
    err_nxt    = 1'b0;
    code_nxt   = err_code;

    case (state)
      ST_IDLE, ST_WAIT_ACK: begin
        // A byte arriving alongside cmd_ready is parsed as the start of the next packet
        if (state == ST_IDLE || cmd_ready) begin
          if (state == ST_WAIT_ACK) begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end
          if (accept) begin
            if (rx_frame == HCI_PKT_CMD) begin
              state_nxt = ST_OPC_LO;
            end else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_BAD_IND;
            end
          end
        end else if (accept) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_OVERRUN;
        end
      end
      default: begin
        if (frame_error) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_FRAMING;
          state_nxt = ST_IDLE;
        end else if (accept) begin
          tmr_nxt = '0;
          case (state)
            ST_OPC_LO: begin
              opcode_nxt[7:0] = rx_frame;
              state_nxt       = ST_OPC_HI;
            end
            ST_OPC_HI: begin
              opcode_nxt[15:8] = rx_frame;
              state_nxt        = ST_PLEN;
            end
            ST_PLEN: begin
              len_nxt = rx_frame;
              cnt_nxt = '0;
              if (rx_frame == 8'd0) begin
                valid_nxt = 1'b1;
                state_nxt = ST_WAIT_ACK;
              end else if ({1'b0, rx_frame} > 9'(MAX_PARAM_LEN)) begin
                state_nxt = ST_DISCARD;
              end else begin
                state_nxt = ST_PARAM;
              end
            end
            ST_PARAM: begin
              we_nxt   = 1'b1;
              addr_nxt = cnt[PADDR_W-1:0];
              data_nxt = rx_frame;
              cnt_nxt  = cnt + 8'd1;
              if (last_byte) begin
                valid_nxt = 1'b1;
                state_nxt = ST_WAIT_ACK;
              end
            end
            default: begin
              cnt_nxt = cnt + 8'd1;
              if (last_byte) begin
                err_nxt   = 1'b1;
                code_nxt  = ERR_TOO_LONG;
                state_nxt = ST_IDLE;
              end
            end
          endcase
        end else if (tmr == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_TIMEOUT;
          state_nxt = ST_IDLE;
        end
      end
    endcase

    if (state_nxt == ST_IDLE || state_nxt == ST_WAIT_ACK || state == ST_IDLE) begin
      tmr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tmr           <= '0;
      cnt           <= '0;
      cmd_valid     <= 1'b0;
      cmd_opcode    <= '0;
      cmd_param_len <= '0;
      param_we      <= 1'b0;
      param_addr    <= '0;
      param_data    <= '0;
      err_pulse     <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      state         <= state_nxt;
      tmr           <= tmr_nxt;
      cnt           <= cnt_nxt;
      cmd_valid     <= valid_nxt;
      cmd_opcode    <= opcode_nxt;
      cmd_param_len <= len_nxt;
      param_we      <= we_nxt;
      param_addr    <= addr_nxt;
      param_data    <= data_nxt;
      err_pulse     <= err_nxt;
      err_code      <= code_nxt;
    end
  end

endmodule

// File: tb/tb_btle_hci_cmd_parser.sv
// Bench for btle_hci_cmd_parser: packet-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_btle_hci_cmd_parser;

  localparam int MAXP = 64;
  localparam int TOC  = 4 * 10 * (16_000_000 / 115200);
  localparam int PW   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_frame = 8'h00;
  logic          rx_done = 1'b0;
  logic          frame_error = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [15:0]   cmd_opcode;
  logic [7:0]    cmd_param_len;
  logic          param_we;
  logic [PW-1:0] param_addr;
  logic [7:0]    param_data;
  logic          err_pulse;
  logic [2:0]    err_code;

  int checks = 0;
  int errors = 0;

  btle_hci_cmd_parser dut (
    .clk(clk), .rst_n(rst_n), .rx_frame(rx_frame), .rx_done(rx_done),
    .frame_error(frame_error), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_param_len(cmd_param_len), .param_we(param_we),
    .param_addr(param_addr), .param_data(param_data), .err_pulse(err_pulse),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Reference model: tracks position inside the packet and a pending command.
  int          m_pos = 0;
  bit          m_presented = 1'b0;
  int          m_n = 0;
  int          m_quiet = 0;
  logic        e_valid = 0, e_we = 0, e_err = 0;
  logic [15:0] e_op = 0;
  logic [7:0]  e_len = 0, e_data = 0;
  logic [PW-1:0] e_addr = 0;
  logic [2:0]  e_code = 0;

  task automatic m_flag(input logic [2:0] c);
    e_err = 1'b1;
    e_code = c;
  endtask

  task automatic m_start(input logic [7:0] b);
    if (b == 8'h01) begin
      m_pos = 1;
      m_quiet = 0;
    end else m_flag(3'd1);
  endtask

  task automatic m_present();
    m_presented = 1'b1;
    e_valid = 1'b1;
    m_pos = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_presented = 0; m_n = 0; m_quiet = 0;
      e_valid = 0; e_we = 0; e_err = 0; e_op = 0; e_len = 0;
      e_data = 0; e_addr = 0; e_code = 0;
    end else begin
      bit acc;
      acc = rx_done && !frame_error;
      e_we = 0;
      e_err = 0;
      if (m_presented) begin
        if (cmd_ready) begin
          m_presented = 0;
          e_valid = 0;
          if (acc) m_start(rx_frame);
        end else if (acc) m_flag(3'd5);
      end else if (m_pos == 0) begin
        if (acc) m_start(rx_frame);
      end else if (frame_error) begin
        m_flag(3'd2);
        m_pos = 0;
      end else if (acc) begin
        m_quiet = 0;
        if (m_pos == 1) begin
          e_op[7:0] = rx_frame; m_pos = 2;
        end else if (m_pos == 2) begin
          e_op[15:8] = rx_frame; m_pos = 3;
        end else if (m_pos == 3) begin
          e_len = rx_frame; m_n = 0;
          if (rx_frame == 0) m_present();
          else m_pos = 4;
        end else begin
          if (e_len <= MAXP) begin
            e_we = 1; e_addr = PW'(m_n); e_data = rx_frame;
            m_n++;
            if (m_n == e_len) m_present();
          end else begin
            m_n++;
            if (m_n == e_len) begin
              m_flag(3'd4);
              m_pos = 0;
            end
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == TOC) begin
          m_flag(3'd3);
          m_pos = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [43:0] act, exp;
    #1;
    act = {cmd_valid, cmd_opcode, cmd_param_len, param_we, param_addr, param_data, err_pulse, err_code};
    exp = {e_valid, e_op, e_len, e_we, e_addr, e_data, e_err, e_code};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_model t=%0t got %h want %h", $time, act, exp);
    end
  end

  // Record every param write together with cmd_valid seen right after it
  logic [14:0] writes[$];
  always @(posedge clk) begin
    #1;
    if (param_we) writes.push_back({cmd_valid, param_addr, param_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_frame = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic handshake();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    writes.delete();
    send(8'h01); send(8'h03); send(8'h0C); send(8'h00);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, "_opcode"}, 32'(cmd_opcode), 32'h0C03);
    check({tag, "_len"}, 32'(cmd_param_len), 32'd0);
    check({tag, "_nowrites"}, writes.size(), 0);
    handshake();
    check({tag, "_valid_after_ready"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    idle(3);
    check("reset_valid", 32'(cmd_valid), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // T1: zero-length command
    run_t1("t1");

    // T2: three params, link layer stalls for 10 cycles
    writes.delete();
    send(8'h01); send(8'h01); send(8'h20); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    check("t2_nwrites", writes.size(), 3);
    if (writes.size() == 3) begin
      check("t2_w0", 32'(writes[0]), 32'(15'h00AA));
      check("t2_w1", 32'(writes[1]), 32'(15'h01BB));
      check("t2_w2_with_valid", 32'(writes[2]), 32'(15'h42CC));
    end
    idle(10);
    check("t2_valid_held", 32'(cmd_valid), 32'd1);
    check("t2_opcode", 32'(cmd_opcode), 32'h2001);
    check("t2_len", 32'(cmd_param_len), 32'd3);
    handshake();
    check("t2_valid_cleared", 32'(cmd_valid), 32'd0);

    // T3: oversize packet discarded, then a normal packet
    writes.delete();
    send(8'h01); send(8'h01); send(8'h20); send(8'h41);
    for (int i = 0; i < 64; i++) send(8'(i));
    check("t3_no_err_before_last", 32'(err_code), 32'd0);
    send(8'h40);
    check("t3_too_long", 32'(err_code), 32'd4);
    check("t3_nowrites", writes.size(), 0);
    run_t1("t3_after");

    // T4: inter-byte timeout, then a bad indicator in IDLE
    send(8'h01); send(8'h01); send(8'h20); send(8'h02); send(8'hAA);
    lat = -1;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      if (err_code == 3'd3) begin
        lat = i;
        break;
      end
    end
    check("t4_timeout_latency", 32'(lat), 32'd5520);
    check("t4_no_valid", 32'(cmd_valid), 32'd0);
    send(8'h55);
    check("t4_bad_ind", 32'(err_code), 32'd1);

    // T5: framing error mid-param, then overrun while waiting for ready
    send(8'h01); send(8'h01); send(8'h20); send(8'h02); send(8'hAA);
    @(negedge clk);
    frame_error = 1'b1;
    @(negedge clk);
    frame_error = 1'b0;
    check("t5_framing", 32'(err_code), 32'd2);
    idle(3);
    check("t5_no_valid", 32'(cmd_valid), 32'd0);
    send(8'h01); send(8'h03); send(8'h0C); send(8'h00);
    send(8'h77);
    check("t5_overrun", 32'(err_code), 32'd5);
    check("t5_valid_kept", 32'(cmd_valid), 32'd1);
    handshake();

    // T6: asynchronous reset mid-param
    send(8'h01); send(8'h01); send(8'h20); send(8'h03); send(8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'({cmd_valid, cmd_opcode, cmd_param_len, param_we, err_pulse, err_code,
                                 param_addr, param_data} == '0), 32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    run_t1("t6_after");

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
